// File: rtl/poly_ctrl_pkg.sv
// Shared types for the polynomial controller: state enum,
// datapath control word layout and the per-step control words.
package poly_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CLR,
      S_B,
      S_C,
      S_D,
      S_E,
      S_F,
      S_G,
      S_H,
      S_I,
      S_J,
      S_K,
      S_DONE
   } state_t;

   typedef struct packed {
      logic [1:0] m0;
      logic [1:0] m1;
      logic [1:0] m2;
      logic       lx;
      logic       ls;
      logic       lh;
      logic       h;
   } ctrl_word_t;

   localparam ctrl_word_t CW_IDLE = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam ctrl_word_t CW_B    = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1};
   localparam ctrl_word_t CW_C    = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1};
   localparam ctrl_word_t CW_D    = '{2'b01, 2'b01, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1};
   localparam ctrl_word_t CW_E    = '{2'b01, 2'b01, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1};
   localparam ctrl_word_t CW_F    = '{2'b10, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1};
   localparam ctrl_word_t CW_G    = '{2'b10, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1};
   localparam ctrl_word_t CW_H    = '{2'b00, 2'b11, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0};
   localparam ctrl_word_t CW_I    = '{2'b00, 2'b11, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0};
   localparam ctrl_word_t CW_J    = '{2'b11, 2'b01, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0};
   localparam ctrl_word_t CW_K    = '{2'b11, 2'b01, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0};

   // CLR, B..K and DONE are consecutive in the encoding
   function automatic state_t step_next(state_t s);
      return state_t'(s + 4'd1);
   endfunction

endpackage

// File: rtl/poly_ctrl_decode.sv
// State to datapath control word ROM.
// Non-compute states map to the idle word.
module poly_ctrl_decode
   import poly_ctrl_pkg::*;
(
   input  state_t     st,
   output ctrl_word_t cw
);

   always_comb begin
      cw = CW_IDLE;
      unique case (st)
         S_B:     cw = CW_B;
         S_C:     cw = CW_C;
         S_D:     cw = CW_D;
         S_E:     cw = CW_E;
         S_F:     cw = CW_F;
         S_G:     cw = CW_G;
         S_H:     cw = CW_H;
         S_I:     cw = CW_I;
         S_J:     cw = CW_J;
         S_K:     cw = CW_K;
         default: cw = CW_IDLE;
      endcase
   end

endmodule

// File: rtl/poly_ctrl.sv
// Sequencer for the polynomial datapath: R1 = A*X*X + B*X + C.
// Start/done handshake, stall hold and completed-run counter.
module poly_ctrl
   import poly_ctrl_pkg::*;
#(
   parameter bit CLR_ON_START = 1'b1,
   parameter int CNT_W        = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stall,
   output logic [1:0]       m0,
   output logic [1:0]       m1,
   output logic [1:0]       m2,
   output logic             lx,
   output logic             ls,
   output logic             lh,
   output logic             h,
   output logic             dp_rst,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] runs_cnt
);

   state_t     st;
   logic       frz;
   ctrl_word_t rom;
   ctrl_word_t cw;
   state_t     nxt;

   poly_ctrl_decode u_dec (
      .st (st),
      .cw (rom)
   );

   assign nxt = step_next(st);

   // frz marks a held step: idle word now, real word once released
   always_comb begin
      cw = rom;
      if (frz)
         cw = CW_IDLE;
   end

   assign m0     = cw.m0;
   assign m1     = cw.m1;
   assign m2     = cw.m2;
   assign lx     = cw.lx;
   assign ls     = cw.ls;
   assign lh     = cw.lh;
   assign h      = cw.h;
   assign dp_rst = (st == S_CLR) && !frz;
   assign busy   = (st != S_IDLE);
   assign done   = (st == S_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= S_IDLE;
         frz      <= 1'b0;
         runs_cnt <= '0;
      end else begin
         unique case (st)
            S_IDLE: begin
               frz <= 1'b0;
               if (start)
                  st <= CLR_ON_START ? S_CLR : S_B;
            end
            S_DONE: begin
               frz      <= 1'b0;
               st       <= S_IDLE;
               runs_cnt <= runs_cnt + 1'b1;
            end
            default: begin
               if (frz) begin
                  frz <= stall;
               end else begin
                  st  <= nxt;
                  frz <= stall && (nxt != S_DONE);
               end
            end
         endcase
      end
   end

endmodule
